mu0_seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the MU0/ARM-extension datapath ALU.
- Executes single-cycle ADD/SUB/MOV/XSR and adds iterative multi-bit shifts (LSLN/LSRN) and an unsigned shift-add multiply.
- Holds the CARRY and SKIP flags internally and handles skip-squash itself.
- Sits between the register file read ports and the Rd write port; the control FSM issues one operation via start/done handshake.

---
 rtl/mu0_seq_alu.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_mu0_seq_alu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_seq_alu.sv
// mu0_seq_alu -- multi-cycle MU0/ARM-extension datapath ALU.
//
// One operation is issued through a start/done handshake. ADD, SUB, MOV, XSR
// and the reserved code finish in one cycle. LSLN/LSRN shift Rd by
// k = Rs[SHW-1:0] bits, one bit per cycle. MUL is an unsigned shift-add
// multiply taking WIDTH cycles. The CARRY and SKIP flags live here, and an
// operation issued while SKIP is set is squashed (no write, CARRY kept).
//
// Optional feature macro: MU0_ALU_MUL_EN
//   defined   -> op 110 is the iterative multiplier
//   undefined -> multiplier removed, op 110 behaves like reserved op 111
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_start      issue request, accepted only while o_busy = 0
//   i_op[2:0]    000 ADD, 001 SUB, 010 MOV, 011 XSR, 100 LSLN, 101 LSRN,
//                110 MUL, 111 reserved
//   i_cin_sel    carry-in: 00 -> 0, 01 -> 1, 10 -> CARRY, 11 -> Rs msb
//   i_cw         write CARRY at completion
//   i_cond[3:0]  skip condition: 0001 always, 0010 C=1, 0011 C=0, else never
//   i_rd_data    Rd operand
//   i_rs_data    Rs operand
//   o_result     registered result, valid while o_done = 1
//   o_done       one-cycle completion pulse
//   o_wen        Rd write enable, pulses with o_done unless squashed
//   o_busy       high from the cycle after acceptance through the done cycle
//   o_carry      CARRY flag
//   o_skip       SKIP flag
module mu0_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [1:0]       i_cin_sel,
  input  logic             i_cw,
  input  logic [3:0]       i_cond,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic [WIDTH-1:0] i_rs_data,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_wen,
  output logic             o_busy,
  output logic             o_carry,
  output logic             o_skip
);

  // Counter is one bit wider than the shift amount so it can hold WIDTH.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_XSR  = 3'b011;
  localparam logic [2:0] OP_LSLN = 3'b100;
  localparam logic [2:0] OP_LSRN = 3'b101;
`ifdef MU0_ALU_MUL_EN
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Skip condition decode against the given CARRY value.
  function automatic logic cond_true(input logic [3:0] cond, input logic carry);
    logic t;
    case (cond)
      4'b0001: t = 1'b1;
      4'b0010: t = carry;
      4'b0011: t = ~carry;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_done, w_done_nxt;
  logic             r_wen, w_wen_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_skip, w_skip_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic             r_cw, w_cw_nxt;
  logic [3:0]       r_cond, w_cond_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
`ifdef MU0_ALU_MUL_EN
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH:0]   w_madd;
`endif

  logic             w_cin;
  logic [WIDTH-1:0] w_adda, w_addb;
  logic [WIDTH:0]   w_sum;
  logic [CW-1:0]    w_k;
  logic             w_fin, w_squash;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_cout, w_fin_cw;
  logic [3:0]       w_fin_cond;
  logic             w_step_cout;

  assign w_k = {1'b0, i_rs_data[SHW-1:0]};

  // Carry-in selection and the zero-extended adder for single-cycle ops.
  always_comb begin
    case (i_cin_sel)
      2'b00:   w_cin = 1'b0;
      2'b01:   w_cin = 1'b1;
      2'b10:   w_cin = r_carry;
      2'b11:   w_cin = i_rs_data[WIDTH-1];
      default: w_cin = 1'b0;
    endcase
    case (i_op)
      OP_SUB: begin
        w_adda = i_rd_data;
        w_addb = ~i_rs_data;
      end
      OP_MOV: begin
        w_adda = {WIDTH{1'b0}};
        w_addb = i_rs_data;
      end
      default: begin
        w_adda = i_rd_data;
        w_addb = i_rs_data;
      end
    endcase
    w_sum = {1'b0, w_adda} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_cin};
  end

  // Next-state, datapath step and flag update logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    w_wen_nxt    = 1'b0;
    w_carry_nxt  = r_carry;
    w_skip_nxt   = r_skip;
    w_op_nxt     = r_op;
    w_cw_nxt     = r_cw;
    w_cond_nxt   = r_cond;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_fin        = 1'b0;
    w_squash     = 1'b0;
    w_fin_res    = {WIDTH{1'b0}};
    w_fin_cout   = 1'b0;
    w_fin_cw     = i_cw;
    w_fin_cond   = i_cond;
    w_step_cout  = 1'b0;
`ifdef MU0_ALU_MUL_EN
    w_hi_nxt     = r_hi;
    w_mcand_nxt  = r_mcand;
    w_madd       = {(WIDTH+1){1'b0}};
`endif

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (r_skip) begin
            w_squash = 1'b1;
          end else begin
            case (i_op)
              OP_ADD, OP_SUB, OP_MOV: begin
                w_fin      = 1'b1;
                w_fin_res  = w_sum[WIDTH-1:0];
                w_fin_cout = w_sum[WIDTH];
              end
              OP_XSR: begin
                w_fin      = 1'b1;
                w_fin_res  = {w_cin, i_rs_data[WIDTH-1:1]};
                w_fin_cout = i_rs_data[0];
              end
              OP_LSLN, OP_LSRN: begin
                if (w_k == {CW{1'b0}}) begin
                  // Zero-length shift: Rd passes through, nothing shifted out.
                  w_fin      = 1'b1;
                  w_fin_res  = i_rd_data;
                  w_fin_cout = 1'b0;
                end else begin
                  w_state_nxt = S_RUN;
                  w_op_nxt    = i_op;
                  w_cw_nxt    = i_cw;
                  w_cond_nxt  = i_cond;
                  w_acc_nxt   = i_rd_data;
                  w_cnt_nxt   = w_k;
                end
              end
`ifdef MU0_ALU_MUL_EN
              OP_MUL: begin
                // Multiplier sits in the low half and is consumed lsb first.
                w_state_nxt = S_RUN;
                w_op_nxt    = i_op;
                w_cw_nxt    = i_cw;
                w_cond_nxt  = i_cond;
                w_acc_nxt   = i_rs_data;
                w_hi_nxt    = {WIDTH{1'b0}};
                w_mcand_nxt = i_rd_data;
                w_cnt_nxt   = CNT_MUL;
              end
`endif
              default: begin
                w_fin      = 1'b1;
                w_fin_res  = {WIDTH{1'b0}};
                w_fin_cout = 1'b0;
              end
            endcase
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RUN: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        case (r_op)
          OP_LSLN: begin
            w_acc_nxt   = {r_acc[WIDTH-2:0], 1'b0};
            w_step_cout = r_acc[WIDTH-1];
          end
          OP_LSRN: begin
            w_acc_nxt   = {1'b0, r_acc[WIDTH-1:1]};
            w_step_cout = r_acc[0];
          end
`ifdef MU0_ALU_MUL_EN
          OP_MUL: begin
            // Add multiplicand when the current multiplier bit is set, then
            // shift the {hi, lo} pair right by one.
            w_madd      = r_acc[0] ? ({1'b0, r_hi} + {1'b0, r_mcand}) : {1'b0, r_hi};
            w_hi_nxt    = w_madd[WIDTH:1];
            w_acc_nxt   = {w_madd[0], r_acc[WIDTH-1:1]};
            w_step_cout = |w_madd[WIDTH:1];
          end
`endif
          default: begin
            w_acc_nxt   = r_acc;
            w_step_cout = 1'b0;
          end
        endcase
        if (r_cnt == CNT_ONE) begin
          w_fin      = 1'b1;
          w_fin_res  = w_acc_nxt;
          w_fin_cout = w_step_cout;
          w_fin_cw   = r_cw;
          w_fin_cond = r_cond;
        end else begin
          w_state_nxt = S_RUN;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Completion: flags change on the DONE-entry edge; SKIP is judged
    // against the CARRY value from before this operation.
    if (w_fin) begin
      w_state_nxt  = S_DONE;
      w_done_nxt   = 1'b1;
      w_wen_nxt    = 1'b1;
      w_result_nxt = w_fin_res;
      w_carry_nxt  = w_fin_cw ? w_fin_cout : r_carry;
      w_skip_nxt   = cond_true(w_fin_cond, r_carry);
    end else if (w_squash) begin
      w_state_nxt  = S_DONE;
      w_done_nxt   = 1'b1;
      w_wen_nxt    = 1'b0;
      w_result_nxt = {WIDTH{1'b0}};
      w_carry_nxt  = r_carry;
      w_skip_nxt   = 1'b0;
    end else begin
      w_done_nxt   = 1'b0;
      w_wen_nxt    = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, datapath and flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_result <= {WIDTH{1'b0}};
      r_done   <= 1'b0;
      r_wen    <= 1'b0;
      r_busy   <= 1'b0;
      r_carry  <= 1'b0;
      r_skip   <= 1'b0;
      r_op     <= 3'b000;
      r_cw     <= 1'b0;
      r_cond   <= 4'b0000;
      r_acc    <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
`ifdef MU0_ALU_MUL_EN
      r_hi     <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
      r_wen    <= w_wen_nxt;
      r_busy   <= w_busy_nxt;
      r_carry  <= w_carry_nxt;
      r_skip   <= w_skip_nxt;
      r_op     <= w_op_nxt;
      r_cw     <= w_cw_nxt;
      r_cond   <= w_cond_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
`ifdef MU0_ALU_MUL_EN
      r_hi     <= w_hi_nxt;
      r_mcand  <= w_mcand_nxt;
`endif
    end
  end

  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_wen    = r_wen;
  assign o_busy   = r_busy;
  assign o_carry  = r_carry;
  assign o_skip   = r_skip;

endmodule

// File: tb/tb_mu0_seq_alu.sv
// Self-checking bench for mu0_seq_alu (WIDTH = 16). Expected values come from
// a behavioural model using plain integer arithmetic; MU0_ALU_MUL_EN selects
// which op 110 behaviour the model expects.
module tb_mu0_seq_alu;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_cw;
  logic [2:0]  i_op;
  logic [1:0]  i_cin_sel;
  logic [3:0]  i_cond;
  logic [15:0] i_rd_data, i_rs_data;
  logic [15:0] o_result;
  logic        o_done, o_wen, o_busy, o_carry, o_skip;

  int n_checks = 0;
  int n_fail   = 0;
  logic m_carry = 1'b0;
  logic m_skip  = 1'b0;

  always #5 clk = ~clk;

  mu0_seq_alu #(.WIDTH(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_cin_sel(i_cin_sel), .i_cw(i_cw), .i_cond(i_cond),
    .i_rd_data(i_rd_data), .i_rs_data(i_rs_data),
    .o_result(o_result), .o_done(o_done), .o_wen(o_wen), .o_busy(o_busy),
    .o_carry(o_carry), .o_skip(o_skip)
  );

  // Reference model: computes expected result/latency/wen and advances flags.
  task automatic model(input logic [2:0] op, input logic [1:0] cs, input logic cw,
                       input logic [3:0] cond, input logic [15:0] rd, input logic [15:0] rs,
                       output logic [15:0] e_res, output int e_lat, output logic e_wen);
    logic cin, cout, new_skip;
    int unsigned t;
    int k;
    k = int'(rs[3:0]);
    case (cs)
      2'd0: cin = 1'b0;
      2'd1: cin = 1'b1;
      2'd2: cin = m_carry;
      default: cin = rs[15];
    endcase
    e_lat = 1; e_res = 16'h0000; cout = 1'b0; t = 0;
    case (op)
      3'd0: begin t = 32'(rd) + 32'(rs) + 32'(cin); e_res = t[15:0]; cout = t[16]; end
      3'd1: begin t = 32'(rd) + (32'hFFFF - 32'(rs)) + 32'(cin); e_res = t[15:0]; cout = t[16]; end
      3'd2: begin t = 32'(rs) + 32'(cin); e_res = t[15:0]; cout = t[16]; end
      3'd3: begin e_res = {cin, rs[15:1]}; cout = rs[0]; end
      3'd4: begin t = 32'(rd) << k; e_res = t[15:0]; cout = (k == 0) ? 1'b0 : t[16]; e_lat = k + 1; end
      3'd5: begin
        e_res = rd >> k; e_lat = k + 1;
        if (k == 0) cout = 1'b0; else begin t = 32'(rd) >> (k - 1); cout = t[0]; end
      end
`ifdef MU0_ALU_MUL_EN
      3'd6: begin t = 32'(rd) * 32'(rs); e_res = t[15:0]; cout = (t[31:16] != 16'h0000); e_lat = 17; end
`endif
      default: begin e_res = 16'h0000; cout = 1'b0; end
    endcase
    if (m_skip) begin
      e_wen = 1'b0; e_lat = 1; m_skip = 1'b0;
    end else begin
      e_wen = 1'b1;
      new_skip = (cond == 4'd1) || (cond == 4'd2 && m_carry) || (cond == 4'd3 && !m_carry);
      if (cw) m_carry = cout;
      m_skip = new_skip;
    end
  endtask

  // Issues one operation and waits (bounded) for done; samples at negedge.
  task automatic do_op(input logic [2:0] op, input logic [1:0] cs, input logic cw,
                       input logic [3:0] cond, input logic [15:0] rd, input logic [15:0] rs,
                       output int lat, output logic [15:0] res, output logic w,
                       output logic c, output logic s, output logic b);
    @(negedge clk);
    i_op = op; i_cin_sel = cs; i_cw = cw; i_cond = cond; i_rd_data = rd; i_rs_data = rs;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_op = 3'($urandom); i_cin_sel = 2'($urandom); i_cw = 1'($urandom);
    i_cond = 4'($urandom); i_rd_data = 16'($urandom); i_rs_data = 16'($urandom);
    lat = 1;
    while (o_done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    res = o_result; w = o_wen; c = o_carry; s = o_skip; b = o_busy;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h exp 0000", o_result); end
    n_checks++; if ({o_done, o_wen, o_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got done/wen/busy=%b exp 000", {o_done, o_wen, o_busy}); end
    n_checks++; if ({o_carry, o_skip} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got carry/skip=%b exp 00", {o_carry, o_skip}); end
    i_reset = 1'b0;
    m_carry = 1'b0; m_skip = 1'b0;
  endtask

  task automatic test_add();
    int lat, el; logic [15:0] r, er; logic w, c, s, b, ew;
    model(3'd0, 2'd0, 1'b1, 4'd0, 16'hFFFF, 16'h0001, er, el, ew);
    do_op(3'd0, 2'd0, 1'b1, 4'd0, 16'hFFFF, 16'h0001, lat, r, w, c, s, b);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", lat); end
    n_checks++; if (r !== 16'h0000 || c !== 1'b1) begin n_fail++; $display("FAIL add_result got %h c=%b exp 0000 c=1", r, c); end
    n_checks++; if (w !== 1'b1 || b !== 1'b1) begin n_fail++; $display("FAIL add_wen_busy got wen=%b busy=%b exp 1 1", w, b); end
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL add_after got busy=%b done=%b exp 0 0", o_busy, o_done); end
  endtask

  task automatic test_shift();
    int lat, el; logic [15:0] r, er, rd, rs; logic w, c, s, b, ew; logic [2:0] op;
    model(3'd4, 2'd0, 1'b1, 4'd0, 16'h1234, 16'h0004, er, el, ew);
    do_op(3'd4, 2'd0, 1'b1, 4'd0, 16'h1234, 16'h0004, lat, r, w, c, s, b);
    n_checks++; if (lat !== 5 || r !== 16'h2340 || c !== 1'b1) begin n_fail++; $display("FAIL lsln got lat=%0d %h c=%b exp 5 2340 1", lat, r, c); end
    model(3'd5, 2'd0, 1'b1, 4'd0, 16'h8001, 16'h0004, er, el, ew);
    do_op(3'd5, 2'd0, 1'b1, 4'd0, 16'h8001, 16'h0004, lat, r, w, c, s, b);
    n_checks++; if (lat !== 5 || r !== 16'h0800 || c !== 1'b0) begin n_fail++; $display("FAIL lsrn got lat=%0d %h c=%b exp 5 0800 0", lat, r, c); end
    model(3'd4, 2'd0, 1'b1, 4'd0, 16'hBEEF, 16'hFFF0, er, el, ew);
    do_op(3'd4, 2'd0, 1'b1, 4'd0, 16'hBEEF, 16'hFFF0, lat, r, w, c, s, b);
    n_checks++; if (lat !== 1 || r !== 16'hBEEF || c !== 1'b0) begin n_fail++; $display("FAIL shift_k0 got lat=%0d %h c=%b exp 1 beef 0", lat, r, c); end
    for (int i = 0; i < 12; i++) begin
      op = (i % 2 == 0) ? 3'd4 : 3'd5;
      rd = 16'($urandom); rs = 16'($urandom);
      model(op, 2'd0, 1'b1, 4'd0, rd, rs, er, el, ew);
      do_op(op, 2'd0, 1'b1, 4'd0, rd, rs, lat, r, w, c, s, b);
      n_checks++; if (lat !== el || r !== er || c !== m_carry) begin n_fail++; $display("FAIL shift_rand op=%0d rd=%h k=%0d got lat=%0d %h c=%b exp %0d %h %b", op, rd, rs[3:0], lat, r, c, el, er, m_carry); end
    end
  endtask

  task automatic test_mul();
    int lat, el; logic [15:0] r, er, rd, rs; logic w, c, s, b, ew;
    model(3'd6, 2'd0, 1'b1, 4'd0, 16'h0100, 16'h0100, er, el, ew);
    do_op(3'd6, 2'd0, 1'b1, 4'd0, 16'h0100, 16'h0100, lat, r, w, c, s, b);
`ifdef MU0_ALU_MUL_EN
    n_checks++; if (lat !== 17 || r !== 16'h0000 || c !== 1'b1) begin n_fail++; $display("FAIL mul_ovf got lat=%0d %h c=%b exp 17 0000 1", lat, r, c); end
    model(3'd6, 2'd0, 1'b1, 4'd0, 16'h0003, 16'h0005, er, el, ew);
    do_op(3'd6, 2'd0, 1'b1, 4'd0, 16'h0003, 16'h0005, lat, r, w, c, s, b);
    n_checks++; if (lat !== 17 || r !== 16'h000F || c !== 1'b0) begin n_fail++; $display("FAIL mul_small got lat=%0d %h c=%b exp 17 000f 0", lat, r, c); end
`else
    n_checks++; if (lat !== 1 || r !== 16'h0000 || c !== 1'b0 || w !== 1'b1) begin n_fail++; $display("FAIL mul_disabled got lat=%0d %h c=%b w=%b exp 1 0000 0 1", lat, r, c, w); end
`endif
    for (int i = 0; i < 4; i++) begin
      rd = 16'($urandom); rs = 16'($urandom_range(0, 1023));
      model(3'd6, 2'd0, 1'b1, 4'd0, rd, rs, er, el, ew);
      do_op(3'd6, 2'd0, 1'b1, 4'd0, rd, rs, lat, r, w, c, s, b);
      n_checks++; if (lat !== el || r !== er || c !== m_carry) begin n_fail++; $display("FAIL mul_rand rd=%h rs=%h got lat=%0d %h c=%b exp %0d %h %b", rd, rs, lat, r, c, el, er, m_carry); end
    end
  endtask

  task automatic test_skip();
    int lat, el; logic [15:0] r, er; logic w, c, s, b, ew; logic c_before;
    model(3'd0, 2'd0, 1'b0, 4'd1, 16'h0001, 16'h0002, er, el, ew);
    do_op(3'd0, 2'd0, 1'b0, 4'd1, 16'h0001, 16'h0002, lat, r, w, c, s, b);
    n_checks++; if (s !== 1'b1 || r !== 16'h0003) begin n_fail++; $display("FAIL skip_set got skip=%b %h exp 1 0003", s, r); end
    c_before = m_carry;
    model(3'd1, 2'd0, 1'b1, 4'd0, 16'h0005, 16'h0003, er, el, ew);
    do_op(3'd1, 2'd0, 1'b1, 4'd0, 16'h0005, 16'h0003, lat, r, w, c, s, b);
    n_checks++; if (lat !== 1 || w !== 1'b0) begin n_fail++; $display("FAIL skip_squash got lat=%0d wen=%b exp 1 0", lat, w); end
    n_checks++; if (c !== c_before || s !== 1'b0) begin n_fail++; $display("FAIL skip_flags got carry=%b skip=%b exp %b 0", c, s, c_before); end
  endtask

  task automatic test_handshake();
    int lat, el, ndone, first; logic [15:0] r, er; logic w, c, s, b, ew;
    logic [2:0] op; logic [15:0] rd, rs;
`ifdef MU0_ALU_MUL_EN
    op = 3'd6; rd = 16'h00C3; rs = 16'h0011;
`else
    op = 3'd4; rd = 16'h00C3; rs = 16'h000F;
`endif
    model(op, 2'd0, 1'b1, 4'd0, rd, rs, er, el, ew);
    @(negedge clk);
    i_op = op; i_cin_sel = 2'd0; i_cw = 1'b1; i_cond = 4'd0; i_rd_data = rd; i_rs_data = rs;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_op = 3'd0; i_cond = 4'd1;
    ndone = 0; first = 0; r = 16'h0000;
    for (int i = 1; i <= 30; i++) begin
      if (o_done === 1'b1) begin
        ndone++;
        if (first == 0) begin first = i; r = o_result; end
      end
      i_start = (i >= 2 && i <= 4);
      @(negedge clk);
    end
    i_start = 1'b0;
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL hs_done_count got %0d exp 1", ndone); end
    n_checks++; if (first !== el || r !== er) begin n_fail++; $display("FAIL hs_result got lat=%0d %h exp %0d %h", first, r, el, er); end
    model(3'd3, 2'd1, 1'b1, 4'd0, 16'h0000, 16'h0003, er, el, ew);
    do_op(3'd3, 2'd1, 1'b1, 4'd0, 16'h0000, 16'h0003, lat, r, w, c, s, b);
    n_checks++; if (lat !== 1 || r !== 16'h8001 || c !== 1'b1) begin n_fail++; $display("FAIL xsr got lat=%0d %h c=%b exp 1 8001 1", lat, r, c); end
  endtask

  task automatic test_random();
    int lat, el; logic [15:0] r, er, rd, rs; logic w, c, s, b, ew;
    logic [2:0] op; logic [1:0] cs; logic cw; logic [3:0] cond;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); cs = 2'($urandom); cw = 1'($urandom);
      cond = 4'($urandom_range(0, 4)); rd = 16'($urandom); rs = 16'($urandom);
      model(op, cs, cw, cond, rd, rs, er, el, ew);
      do_op(op, cs, cw, cond, rd, rs, lat, r, w, c, s, b);
      n_checks++;
      if (lat !== el || w !== ew || c !== m_carry || s !== m_skip || (ew && r !== er)) begin
        n_fail++;
        $display("FAIL rand op=%0d cs=%0d cw=%b cond=%0d rd=%h rs=%h got lat=%0d r=%h w=%b c=%b s=%b exp %0d %h %b %b %b",
                 op, cs, cw, cond, rd, rs, lat, r, w, c, s, el, er, ew, m_carry, m_skip);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat, el, seen; logic [15:0] r, er; logic w, c, s, b, ew;
    model(3'd0, 2'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, er, el, ew);
    do_op(3'd0, 2'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, lat, r, w, c, s, b);
    model(3'd0, 2'd0, 1'b1, 4'd0, 16'hFFFF, 16'h0001, er, el, ew);
    do_op(3'd0, 2'd0, 1'b1, 4'd0, 16'hFFFF, 16'h0001, lat, r, w, c, s, b);
    @(negedge clk);
`ifdef MU0_ALU_MUL_EN
    i_op = 3'd6; i_rs_data = 16'h1234;
`else
    i_op = 3'd4; i_rs_data = 16'h000F;
`endif
    i_cin_sel = 2'd0; i_cw = 1'b1; i_cond = 4'd1; i_rd_data = 16'h0F0F; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_done === 1'b1) seen++;
      @(negedge clk);
    end
    i_reset = 1'b1;
    @(negedge clk);
    if (o_done === 1'b1 || o_wen === 1'b1) seen++;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_done got %0d done/wen pulses exp 0", seen); end
    n_checks++; if ({o_busy, o_carry, o_skip} !== 3'b000) begin n_fail++; $display("FAIL abort_state got busy/carry/skip=%b exp 000", {o_busy, o_carry, o_skip}); end
    m_carry = 1'b0; m_skip = 1'b0;
    model(3'd0, 2'd1, 1'b1, 4'd0, 16'h0002, 16'h0003, er, el, ew);
    i_reset = 1'b0;
    i_op = 3'd0; i_cin_sel = 2'd1; i_cw = 1'b1; i_cond = 4'd0; i_rd_data = 16'h0002; i_rs_data = 16'h0003;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++; if (o_done !== 1'b1 || o_wen !== 1'b1 || o_result !== 16'h0006 || o_carry !== 1'b0) begin
      n_fail++; $display("FAIL abort_restart got done=%b wen=%b %h c=%b exp 1 1 0006 0", o_done, o_wen, o_result, o_carry);
    end
    @(negedge clk);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_op = 3'd0; i_cin_sel = 2'd0; i_cw = 1'b0;
    i_cond = 4'd0; i_rd_data = 16'h0000; i_rs_data = 16'h0000;
    test_reset();
    test_add();
    test_shift();
    test_mul();
    test_skip();
    test_handshake();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
